// File: rtl/rxe_preamble_pkg.sv
// rxe_preamble_pkg
// Shared ethernet receive definitions used by the preamble/SFD stripper:
//   - nibble values of the preamble (0x5) and start-of-frame delimiter (0xD)
//   - state encoding of the receive FSM
//   - a saturating increment for the 4-bit preamble counter
package rxe_preamble_pkg;

  localparam logic [3:0] PRE_NIB = 4'h5;
  localparam logic [3:0] SFD_NIB = 4'hD;

  // DATA_LO / DATA_HI name the nibble expected next on the MII bus.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PREAMBLE = 3'd1,
    ST_DATA_LO  = 3'd2,
    ST_DATA_HI  = 3'd3,
    ST_DROP     = 3'd4
  } rx_state_t;

  // Increment that holds at 15 instead of wrapping to 0.
  function automatic logic [3:0] sat_inc4(input logic [3:0] val);
    sat_inc4 = (val == 4'hF) ? 4'hF : (val + 4'd1);
  endfunction

endpackage

// File: rtl/rxe_preamble_if.sv
// rxe_preamble_if
// MII receive nibble stream into the stripper and the byte stream out of it.
//   i_ce    nibble-rate clock enable
//   i_en    block enable
//   i_v     RX_DV from the PHY
//   i_d     RX nibble from the PHY
//   o_v     one-clock strobe, o_d holds a new payload byte
//   o_d     payload byte {high nibble, low nibble}
//   o_frame frame-active level for the downstream stage
//   o_err   one-clock error pulse
// master: the PHY/bench side; slave: the stripper.
interface rxe_preamble_if;
  import rxe_preamble_pkg::*;

  logic       i_ce;
  logic       i_en;
  logic       i_v;
  logic [3:0] i_d;
  logic       o_v;
  logic [7:0] o_d;
  logic       o_frame;
  logic       o_err;

  modport master (
    output i_ce, i_en, i_v, i_d,
    input  o_v, o_d, o_frame, o_err
  );

  modport slave (
    input  i_ce, i_en, i_v, i_d,
    output o_v, o_d, o_frame, o_err
  );

endinterface

// File: rtl/rxe_preamble.sv
// rxe_preamble
// Locates the 0x5...0x5 0xD preamble/SFD in an MII nibble stream, strips it
// and pairs the remaining nibbles into bytes (low nibble first).
// Ports:
//   i_clk    system clock
//   i_reset  asynchronous active-high reset
//   bus      rxe_preamble_if.slave (i_ce, i_en, i_v, i_d in;
//            o_v, o_d, o_frame, o_err out)
// Parameter:
//   MINPREAMBLE  minimum number of 0x5 nibbles before the SFD (1..15)
module rxe_preamble
  import rxe_preamble_pkg::*;
#(
  parameter int MINPREAMBLE = 4
) (
  input  logic               i_clk,
  input  logic               i_reset,
  rxe_preamble_if.slave      bus
);

  localparam logic [3:0] MIN_PRE = 4'(MINPREAMBLE);

  rx_state_t  state_r;
  logic [3:0] pcnt_r;
  logic [3:0] lo_r;
  logic       v_r;
  logic [7:0] d_r;
  logic       frame_r;
  logic       err_r;

  assign bus.o_v     = v_r;
  assign bus.o_d     = d_r;
  assign bus.o_frame = frame_r;
  assign bus.o_err   = err_r;

  // Receive FSM, nibble pairer and registered outputs.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_r <= ST_IDLE;
      pcnt_r  <= 4'd0;
      lo_r    <= 4'd0;
      v_r     <= 1'b0;
      d_r     <= 8'd0;
      frame_r <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      // Strobes default low so they last exactly one i_clk.
      v_r   <= 1'b0;
      err_r <= 1'b0;
      if (!bus.i_en) begin
        // Disabled: quiet immediately, no error for the abandoned frame.
        state_r <= ST_IDLE;
        frame_r <= 1'b0;
      end else if (bus.i_ce) begin
        case (state_r)
          ST_IDLE: begin
            if (bus.i_v && (bus.i_d == PRE_NIB)) begin
              state_r <= ST_PREAMBLE;
              pcnt_r  <= 4'd1;
            end else if (bus.i_v) begin
              state_r <= ST_DROP;
              err_r   <= 1'b1;
            end else begin
              state_r <= ST_IDLE;
            end
          end
          ST_PREAMBLE: begin
            if (!bus.i_v) begin
              // Carrier without SFD: silently discarded.
              state_r <= ST_IDLE;
            end else if (bus.i_d == PRE_NIB) begin
              pcnt_r <= sat_inc4(pcnt_r);
            end else if ((bus.i_d == SFD_NIB) && (pcnt_r >= MIN_PRE)) begin
              state_r <= ST_DATA_LO;
            end else begin
              // Short preamble or a corrupt nibble.
              state_r <= ST_DROP;
              err_r   <= 1'b1;
            end
          end
          ST_DATA_LO: begin
            if (bus.i_v) begin
              lo_r    <= bus.i_d;
              state_r <= ST_DATA_HI;
            end else begin
              state_r <= ST_IDLE;
              frame_r <= 1'b0;
            end
          end
          ST_DATA_HI: begin
            if (bus.i_v) begin
              d_r     <= {bus.i_d, lo_r};
              v_r     <= 1'b1;
              frame_r <= 1'b1;
              state_r <= ST_DATA_LO;
            end else begin
              // Odd nibble count: dribble error at frame end.
              state_r <= ST_IDLE;
              frame_r <= 1'b0;
              err_r   <= 1'b1;
            end
          end
          ST_DROP: begin
            if (!bus.i_v) begin
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_DROP;
            end
          end
          default: begin
            state_r <= ST_IDLE;
            frame_r <= 1'b0;
          end
        endcase
      end else begin
        state_r <= state_r;
      end
    end
  end

endmodule
